// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter: FSM states and latched memory op.
// The optional timeout feature is enabled by defining MEM_ARB_TIMEOUT_EN.
package lc3b_mem_arbiter_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } lc3b_arb_state;

    typedef enum logic [1:0] {
        NONE,
        READ,
        WRITE
    } lc3b_mem_op;

    localparam int ARB_CNT_MIN_W = 8;

    // A write wins when a requester raises both strobes.
    function automatic lc3b_mem_op decode_op(input logic rd, input logic wr);
        if (wr)
            return WRITE;
        else if (rd)
            return READ;
        else
            return NONE;
    endfunction

endpackage

// File: rtl/lc3b_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the active vector so the scan
// starts after last_grant, find the first set bit, then map back to a port.
module lc3b_mem_arbiter_rr_picker #(
    parameter int NUM_PORTS = 3,
    parameter int GRANT_W   = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] active,
    input  logic [GRANT_W-1:0]   last_grant,
    output logic                 found,
    output logic [GRANT_W-1:0]   grant
);

    localparam logic [GRANT_W:0] NP = (GRANT_W+1)'(NUM_PORTS);

    logic [GRANT_W-1:0]     start;
    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [GRANT_W-1:0]     off;
    logic [GRANT_W:0]       sum;

    assign start = (last_grant == GRANT_W'(NUM_PORTS - 1)) ? '0 : last_grant + 1'b1;
    assign dbl   = {active, active};
    assign rot   = dbl[start +: NUM_PORTS];

    // Find-first-set on the rotated vector; lowest offset has priority.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = GRANT_W'(i);
            end
        end
    end

    assign sum   = {1'b0, start} + {1'b0, off};
    assign grant = (sum >= NP) ? GRANT_W'(sum - NP) : sum[GRANT_W-1:0];

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// N-port round-robin memory arbiter, one outstanding transaction at a time.
// Define MEM_ARB_TIMEOUT_EN to abort transactions stuck in BUSY.
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS   = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255,
    parameter int GRANT_W     = $clog2(NUM_PORTS),
    parameter int WMASK_W     = DATA_W / 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req_read,
    input  logic [NUM_PORTS-1:0]           req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]    req_address,
    input  logic [NUM_PORTS*DATA_W-1:0]    req_wdata,
    input  logic [NUM_PORTS*WMASK_W-1:0]   req_byte_enable,
    output logic [NUM_PORTS-1:0]           req_resp,
    output logic [DATA_W-1:0]              req_rdata,
    output logic                           req_err,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-1:0]              mem_address,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic [WMASK_W-1:0]             mem_byte_enable,
    input  logic                           mem_resp,
    input  logic [DATA_W-1:0]              mem_rdata
);

    lc3b_arb_state        state;
    lc3b_mem_op           op_q;
    logic [GRANT_W-1:0]   grant_q;
    logic [GRANT_W-1:0]   last_grant;
    logic [GRANT_W-1:0]   pick;
    logic                 found;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [WMASK_W-1:0]   be_q;
    logic [NUM_PORTS-1:0] active;
    logic                 busy;
    logic                 tmo;
    logic                 done;

    assign active = req_read | req_write;
    assign busy   = (state == BUSY);

    lc3b_mem_arbiter_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .GRANT_W   (GRANT_W)
    ) u_picker (
        .active     (active),
        .last_grant (last_grant),
        .found      (found),
        .grant      (pick)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC) > ARB_CNT_MIN_W) ?
                           $clog2(TIMEOUT_CYC) : ARB_CNT_MIN_W;

    logic [CNT_W-1:0] cnt;

    // Busy-cycle counter: zero on the first BUSY cycle, held at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!busy)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // A memory response in the timeout cycle takes precedence.
    assign tmo = busy && !mem_resp && (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    // Timeout disabled: the comparison is false for any legal TIMEOUT_CYC.
    assign tmo = (TIMEOUT_CYC < 0);
`endif

    assign done = busy && (mem_resp || tmo);

    // Arbitration FSM: grant and latch in IDLE, wait for completion in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_W'(NUM_PORTS - 1);
            grant_q    <= '0;
            op_q       <= NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        assert (!(req_read[pick] && req_write[pick]))
                            else $warning("arbiter: port %0d read+write, write taken", pick);
                        grant_q <= pick;
                        op_q    <= decode_op(req_read[pick], req_write[pick]);
                        addr_q  <= req_address[pick*ADDR_W +: ADDR_W];
                        wdata_q <= req_wdata[pick*DATA_W +: DATA_W];
                        be_q    <= req_byte_enable[pick*WMASK_W +: WMASK_W];
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        last_grant <= grant_q;
                        op_q       <= NONE;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion pulse steered to the granted port only.
    always_comb begin
        req_resp = '0;
        if (done)
            req_resp[grant_q] = 1'b1;
    end

    assign req_err         = tmo;
    assign req_rdata       = tmo ? '0 : mem_rdata;
    assign mem_read        = busy && !tmo && (op_q == READ);
    assign mem_write       = busy && !tmo && (op_q == WRITE);
    assign mem_address     = busy ? addr_q : '0;
    assign mem_wdata       = busy ? wdata_q : '0;
    assign mem_byte_enable = busy ? be_q : '0;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_lc3b_mem_arbiter;

    localparam int NP   = 3;
    localparam int TOUT = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_read;
    logic [2:0]  req_write;
    logic [47:0] req_address;
    logic [47:0] req_wdata;
    logic [5:0]  req_byte_enable;
    logic [2:0]  req_resp;
    logic [15:0] req_rdata;
    logic        req_err;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lc3b_mem_arbiter #(
        .NUM_PORTS   (NP),
        .ADDR_W      (16),
        .DATA_W      (16),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .req_byte_enable (req_byte_enable),
        .req_resp        (req_resp),
        .req_rdata       (req_rdata),
        .req_err         (req_err),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_have = 1'b0;
    int          m_port = 0;
    bit          m_wr   = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wd   = '0;
    logic [1:0]  m_be   = '0;
    int          m_last = NP - 1;
    int          m_bc   = 0;
    int          m_p;

    function automatic bit m_tmo();
        return TMO_EN && m_have && !mem_resp && (m_bc == TOUT);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have = 1'b0;
            m_last = NP - 1;
            m_bc   = 0;
        end else if (m_have) begin
            if (mem_resp || m_tmo()) begin
                m_have = 1'b0;
                m_last = m_port;
            end else begin
                m_bc++;
            end
        end else begin
            for (int k = 1; k <= NP; k++) begin
                m_p = (m_last + k) % NP;
                if (!m_have && (req_read[m_p] || req_write[m_p])) begin
                    m_have = 1'b1;
                    m_bc   = 1;
                    m_port = m_p;
                    m_wr   = req_write[m_p];
                    m_addr = req_address[m_p*16 +: 16];
                    m_wd   = req_wdata[m_p*16 +: 16];
                    m_be   = req_byte_enable[m_p*2 +: 2];
                end
            end
        end
    end

    // Compare every cycle, mid-period, against the model.
    always @(negedge clk) begin
        bit         t;
        logic [2:0] er;
        t  = m_tmo();
        er = (m_have && (mem_resp || t)) ? 3'(1 << m_port) : 3'b000;
        chk("mem_read",  mem_read,  m_have && !m_wr && !t);
        chk("mem_write", mem_write, m_have && m_wr && !t);
        chk("mem_address", mem_address, m_have ? m_addr : 16'h0);
        chk("mem_wdata", mem_wdata, m_have ? m_wd : 16'h0);
        chk("mem_be",    mem_byte_enable, m_have ? m_be : 2'b00);
        chk("req_resp",  req_resp, er);
        chk("req_err",   req_err, t);
        chk("req_rdata", req_rdata, t ? 16'h0 : mem_rdata);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr,
                            input logic [15:0] a, input logic [15:0] d,
                            input logic [1:0] be);
        req_read[p]              = rd;
        req_write[p]             = wr;
        req_address[p*16 +: 16]  = a;
        req_wdata[p*16 +: 16]    = d;
        req_byte_enable[p*2 +: 2] = be;
    endtask

    task automatic clear_all();
        req_read  = '0;
        req_write = '0;
    endtask

    // Wait for a memory op, respond after lat cycles, report which port got resp.
    task automatic serve(input int lat, input logic [15:0] rd, output int port);
        int n;
        n    = 0;
        port = -1;
        while (!(mem_read || mem_write) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL serve_wait: no mem op within 20 cycles at %0t", $time);
            return;
        end
        repeat (lat) tick();
        mem_resp  = 1'b1;
        mem_rdata = rd;
        #1;
        for (int i = 0; i < NP; i++)
            if (req_resp[i]) port = i;
        tick();
        mem_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int got[6];
    int exp_order[6];
    int port;

    initial begin
        rst_n           = 1'b0;
        req_read        = '0;
        req_write       = '0;
        req_address     = '0;
        req_wdata       = '0;
        req_byte_enable = '0;
        mem_resp        = 1'b0;
        mem_rdata       = 16'h0;
        exp_order       = '{0, 1, 2, 0, 1, 2};

        repeat (3) tick();
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_req_resp", req_resp, 3'b000);
        rst_n = 1'b1;
        tick();

        // 1: port1 read 0x1234, memory answers three cycles after the request
        set_port(1, 1'b1, 1'b0, 16'h1234, 16'h0, 2'b11);
        tick();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_addr", mem_address, 16'h1234);
        tick();
        chk("t1_no_resp_yet", req_resp, 3'b000);
        tick();
        mem_resp  = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        chk("t1_req_resp", req_resp, 3'b010);
        chk("t1_rdata", req_rdata, 16'hBEEF);
        tick();
        mem_resp = 1'b0;
        clear_all();
        chk("t1_bubble", mem_read, 1'b0);
        tick();
        chk("t1_no_regrant", mem_read, 1'b0);

        // 2: fresh reset, all three ports read continuously
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int p = 0; p < NP; p++)
            set_port(p, 1'b1, 1'b0, 16'(16'h0100 + p), 16'h0, 2'b11);
        for (int i = 0; i < 6; i++) begin
            serve(0, 16'(16'h1000 + i), port);
            got[i] = port;
        end
        clear_all();
        for (int i = 0; i < 6; i++)
            chk($sformatf("t2_order%0d", i), got[i], exp_order[i]);
        tick();

        // 3: port2 write, request dropped and altered while busy
        set_port(2, 1'b0, 1'b1, 16'h0040, 16'hA5A5, 2'b01);
        tick();
        set_port(2, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 2'b10);
        for (int i = 0; i < 3; i++) begin
            chk("t3_write", mem_write, 1'b1);
            chk("t3_addr", mem_address, 16'h0040);
            chk("t3_wdata", mem_wdata, 16'hA5A5);
            chk("t3_be", mem_byte_enable, 2'b01);
            tick();
        end
        serve(0, 16'h0, port);
        chk("t3_resp_port", port, 2);

        // 4: port0 with read and write both set
        set_port(0, 1'b1, 1'b1, 16'h0002, 16'h1111, 2'b11);
        tick();
        chk("t4_write", mem_write, 1'b1);
        chk("t4_read", mem_read, 1'b0);
        serve(0, 16'h0, port);
        clear_all();
        chk("t4_resp_port", port, 0);
        tick();

        // 5: reset during BUSY, then port0 must win
        set_port(0, 1'b1, 1'b0, 16'h0300, 16'h0, 2'b11);
        set_port(1, 1'b1, 1'b0, 16'h0400, 16'h0, 2'b11);
        tick();
        chk("t5_grant1_addr", mem_address, 16'h0400);
        chk("t5_read", mem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_read", mem_read, 1'b0);
        chk("t5_rst_resp", req_resp, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_after_rst_addr", mem_address, 16'h0300);
        serve(0, 16'h0, port);
        clear_all();
        chk("t5_resp_port", port, 0);

        // mem_resp while idle is ignored
        tick();
        mem_resp = 1'b1;
        #1;
        chk("idle_resp_ignored", req_resp, 3'b000);
        tick();
        mem_resp = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: memory never answers, abort on the eighth BUSY cycle
        set_port(1, 1'b1, 1'b0, 16'h0777, 16'h0, 2'b11);
        tick();
        clear_all();
        mem_rdata = 16'h5555;
        repeat (6) tick();
        chk("t6_cycle7_resp", req_resp, 3'b000);
        tick();
        chk("t6_resp", req_resp, 3'b010);
        chk("t6_err", req_err, 1'b1);
        chk("t6_rdata", req_rdata, 16'h0000);
        chk("t6_read_drop", mem_read, 1'b0);
        tick();
        chk("t6_idle_read", mem_read, 1'b0);
        chk("t6_idle_err", req_err, 1'b0);
        tick();
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
